// File: rtl/trak_quad_decoder.sv
// Two-axis trackball quadrature front end: sync, stability filter, transition decode, 4-bit wrapping position.
// Optional digital-direction emulator compiled in with `define TRAK_QUAD_EMU_EN.
module trak_quad_decoder #(
    parameter int FILT_LEN = 4,
    parameter int EMU_DIV  = 12000
) (
    input  logic       clk_12mhz,
    input  logic       reset_n,
    input  logic       qx_a,
    input  logic       qx_b,
    input  logic       qy_a,
    input  logic       qy_b,
    input  logic       flip,
`ifdef TRAK_QUAD_EMU_EN
    input  logic       emu_en,
    input  logic       emu_left,
    input  logic       emu_right,
    input  logic       emu_up,
    input  logic       emu_down,
`endif
    output logic [7:0] trakball_o,
    output logic [1:0] dir_o,
    output logic       err_o
);

    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
        $error("FILT_LEN must be within 1..15");
    end
    if (EMU_DIV < 2) begin : g_bad_emu_div
        $error("EMU_DIV must be at least 2");
    end

    localparam logic [3:0] FILT_MAX = 4'(FILT_LEN);

    function automatic logic [1:0] step_fwd(input logic [1:0] s);
        return {~s[0], s[1]};
    endfunction

    function automatic logic [1:0] step_rev(input logic [1:0] s);
        return {s[0], ~s[1]};
    endfunction

    logic [1:0] phase_raw [2];
    logic [1:0] sync1_q   [2];
    logic [1:0] sync2_q   [2];
    logic [1:0] filt_in   [2];
    logic [1:0] filt_q    [2];
    logic [1:0] filt_d    [2];
    logic [3:0] stab_q    [2];
    logic [3:0] stab_d    [2];
    logic [1:0] acc_q     [2];
    logic [1:0] acc_d     [2];
    logic [3:0] pos_q     [2];
    logic [3:0] pos_d     [2];
    logic [1:0] ref_valid_q, ref_valid_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] ill;
    logic       err_q, err_d;

    assign phase_raw[0] = {qx_a, qx_b};
    assign phase_raw[1] = {qy_a, qy_b};

`ifdef TRAK_QUAD_EMU_EN
    localparam int PRE_W = $clog2(EMU_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(EMU_DIV - 1);

    logic [PRE_W-1:0] pre_q [2];
    logic [PRE_W-1:0] pre_d [2];
    logic [1:0]       gen_q [2];
    logic [1:0]       gen_d [2];
    logic [1:0]       mv_fwd, mv_rev;

    assign mv_fwd = {emu_down, emu_right};
    assign mv_rev = {emu_up, emu_left};

    // Opposing or absent requests park the prescaler so motion starts a full period later.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pre_d[i] = pre_q[i];
            gen_d[i] = gen_q[i];
            if (mv_fwd[i] ^ mv_rev[i]) begin
                if (pre_q[i] == PRE_LAST) begin
                    pre_d[i] = '0;
                    gen_d[i] = mv_fwd[i] ? step_fwd(gen_q[i]) : step_rev(gen_q[i]);
                end else begin
                    pre_d[i] = pre_q[i] + 1'b1;
                end
            end else begin
                pre_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                pre_q[i] <= '0;
                gen_q[i] <= 2'b00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                pre_q[i] <= pre_d[i];
                gen_q[i] <= gen_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_in[i] = emu_en ? gen_q[i] : sync2_q[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_in[i] = sync2_q[i];
        end
    end
`endif

    // A pair is accepted only while it still matches after FILT_LEN stable samples,
    // so a hold of FILT_LEN cycles or less is rejected.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i]      = filt_q[i];
            stab_d[i]      = stab_q[i];
            acc_d[i]       = acc_q[i];
            pos_d[i]       = pos_q[i];
            ref_valid_d[i] = ref_valid_q[i];
            dir_d[i]       = dir_q[i];
            ill[i]         = 1'b0;

            if (filt_in[i] != filt_q[i]) begin
                filt_d[i] = filt_in[i];
                stab_d[i] = 4'd1;
            end else if (stab_q[i] < FILT_MAX) begin
                stab_d[i] = stab_q[i] + 4'd1;
            end

            if ((filt_in[i] == filt_q[i]) && (stab_q[i] == FILT_MAX) &&
                (!ref_valid_q[i] || (filt_q[i] != acc_q[i]))) begin
                acc_d[i]       = filt_q[i];
                ref_valid_d[i] = 1'b1;
                if (ref_valid_q[i]) begin
                    if (filt_q[i] == step_fwd(acc_q[i])) begin
                        dir_d[i] = flip;
                        pos_d[i] = flip ? pos_q[i] - 4'd1 : pos_q[i] + 4'd1;
                    end else if (filt_q[i] == step_rev(acc_q[i])) begin
                        dir_d[i] = ~flip;
                        pos_d[i] = flip ? pos_q[i] + 4'd1 : pos_q[i] - 4'd1;
                    end else begin
                        ill[i] = 1'b1;
                    end
                end
            end
        end
        err_d = |ill;
    end

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                sync1_q[i] <= 2'b00;
                sync2_q[i] <= 2'b00;
                filt_q[i]  <= 2'b00;
                stab_q[i]  <= 4'd0;
                acc_q[i]   <= 2'b00;
                pos_q[i]   <= 4'd0;
            end
            ref_valid_q <= 2'b00;
            dir_q       <= 2'b00;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync1_q[i] <= phase_raw[i];
                sync2_q[i] <= sync1_q[i];
                filt_q[i]  <= filt_d[i];
                stab_q[i]  <= stab_d[i];
                acc_q[i]   <= acc_d[i];
                pos_q[i]   <= pos_d[i];
            end
            ref_valid_q <= ref_valid_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
        end
    end

    assign trakball_o = {pos_q[1], pos_q[0]};
    assign dir_o      = dir_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_trak_quad_decoder.sv
// Directed bench for trak_quad_decoder; emulator vectors run only when TRAK_QUAD_EMU_EN is defined.
module tb_trak_quad_decoder;

    logic       clk_12mhz = 1'b0;
    logic       reset_n   = 1'b0;
    logic       qx_a = 1'b0, qx_b = 1'b0, qy_a = 1'b0, qy_b = 1'b0;
    logic       flip = 1'b0;
`ifdef TRAK_QUAD_EMU_EN
    logic       emu_en = 1'b0, emu_left = 1'b0, emu_right = 1'b0, emu_up = 1'b0, emu_down = 1'b0;
`endif
    logic [7:0] trakball_o;
    logic [1:0] dir_o;
    logic       err_o;

    int n_vec = 0;
    int n_err = 0;
    int err_seen = 0;

    trak_quad_decoder #(.FILT_LEN(4), .EMU_DIV(10)) dut (
        .clk_12mhz (clk_12mhz),
        .reset_n   (reset_n),
        .qx_a      (qx_a),
        .qx_b      (qx_b),
        .qy_a      (qy_a),
        .qy_b      (qy_b),
        .flip      (flip),
`ifdef TRAK_QUAD_EMU_EN
        .emu_en    (emu_en),
        .emu_left  (emu_left),
        .emu_right (emu_right),
        .emu_up    (emu_up),
        .emu_down  (emu_down),
`endif
        .trakball_o(trakball_o),
        .dir_o     (dir_o),
        .err_o     (err_o)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    always @(negedge clk_12mhz) if (err_o) err_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_12mhz);
        #1;
    endtask

    task automatic set_x(input logic [1:0] v, input int n);
        {qx_a, qx_b} = v;
        cyc(n);
    endtask

    logic [1:0] yseq [4];
    int         e0;
    logic [3:0] xsnap;

    initial begin
        yseq[0] = 2'b00; yseq[1] = 2'b01; yseq[2] = 2'b11; yseq[3] = 2'b10;

        cyc(3);
        chk("rst_trak", trakball_o, 8'h00);
        chk("rst_dir", dir_o, 2'b00);
        chk("rst_err", err_o, 1'b0);

        reset_n = 1'b1;
        set_x(2'b00, 20);
        set_x(2'b10, 20);
        chk("x_step1", trakball_o[3:0], 4'd1);
        set_x(2'b11, 20);
        set_x(2'b01, 20);
        set_x(2'b00, 20);
        chk("x_fwd4", trakball_o[3:0], 4'd4);
        chk("x_fwd_dir", dir_o[0], 1'b0);
        chk("x_fwd_noerr", err_seen, 0);
        chk("y_idle", trakball_o[7:4], 4'd0);

        for (int k = 1; k <= 17; k++) begin
            {qy_a, qy_b} = yseq[k % 4];
            cyc(12);
            if (k == 1) chk("y_first_wrap", trakball_o[7:4], 4'd15);
        end
        chk("y_rev17", trakball_o[7:4], 4'd15);
        chk("y_dir", dir_o[1], 1'b1);
        chk("x_indep", trakball_o[3:0], 4'd4);

        e0 = err_seen;
        set_x(2'b10, 3);
        set_x(2'b00, 20);
        chk("glitch_cnt", trakball_o[3:0], 4'd4);
        chk("glitch_err", err_seen - e0, 0);

        set_x(2'b10, 5);
        {qx_a, qx_b} = 2'b00;
        cyc(1);
        chk("lat_edge6", trakball_o[3:0], 4'd4);
        cyc(1);
        chk("lat_edge7", trakball_o[3:0], 4'd5);
        cyc(20);
        chk("lat_back", trakball_o[3:0], 4'd4);
        chk("lat_back_dir", dir_o[0], 1'b1);

        e0 = err_seen;
        set_x(2'b11, 20);
        chk("ill_cnt", trakball_o[3:0], 4'd4);
        chk("ill_pulse", err_seen - e0, 1);
        set_x(2'b01, 20);
        chk("ill_then_fwd", trakball_o[3:0], 4'd5);
        chk("ill_then_dir", dir_o[0], 1'b0);

        set_x(2'b00, 20);
        reset_n = 1'b0;
        cyc(2);
        chk("rst2_trak", trakball_o, 8'h00);
        flip = 1'b1;
        reset_n = 1'b1;
        set_x(2'b00, 20);
        set_x(2'b10, 20);
        set_x(2'b11, 20);
        set_x(2'b01, 20);
        set_x(2'b00, 20);
        chk("flip_cnt", trakball_o[3:0], 4'd12);
        chk("flip_dir", dir_o[0], 1'b1);
        set_x(2'b10, 20);
        chk("flip_cnt2", trakball_o[3:0], 4'd11);
        reset_n = 1'b0;
        #2;
        chk("async_rst_trak", trakball_o, 8'h00);
        chk("async_rst_dir", dir_o, 2'b00);
        cyc(2);
        flip = 1'b0;

`ifdef TRAK_QUAD_EMU_EN
        emu_en  = 1'b1;
        reset_n = 1'b1;
        cyc(20);
        emu_right = 1'b1;
        cyc(100);
        emu_right = 1'b0;
        cyc(20);
        chk("emu_right", (trakball_o[3:0] >= 4'd9) && (trakball_o[3:0] <= 4'd10), 1'b1);
        xsnap = trakball_o[3:0];
        emu_left  = 1'b1;
        emu_right = 1'b1;
        cyc(50);
        emu_left  = 1'b0;
        emu_right = 1'b0;
        cyc(20);
        chk("emu_both", trakball_o[3:0], xsnap);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
